// File: rtl/stopwatch_ctrl_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module   : stopwatch_ctrl_if                                       |
// | Purpose  : Buttons, tick and timer-datapath signals of the         |
// |            stopwatch controller, bundled with master/slave views.  |
// | Revision : 1.0  initial release                                    |
// +--------------------------------------------------------------------+
interface stopwatch_ctrl_if;
  logic        tickIn;
  logic        btnSS;
  logic        btnLR;
  logic [29:0] timeIn;
  logic        timerEn;
  logic        timerClr;
  logic [29:0] dispOut;
  logic [1:0]  state;
  logic [3:0]  lapCount;

  // Environment side: drives buttons, tick and timer value.
  modport master (
    output tickIn, btnSS, btnLR, timeIn,
    input  timerEn, timerClr, dispOut, state, lapCount
  );

  // Controller side.
  modport slave (
    input  tickIn, btnSS, btnLR, timeIn,
    output timerEn, timerClr, dispOut, state, lapCount
  );
endinterface
`default_nettype wire

// File: rtl/stopwatch_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module   : stopwatch_ctrl                                          |
// | Purpose  : Two-button stopwatch sequencer: synchronises and        |
// |            debounces start/stop and lap/reset, gates the timer     |
// |            enable, issues clear pulses and freezes a lap value     |
// |            for the display path.                                   |
// | Options  : LAP_COUNT_EN - enables the saturating lap counter;      |
// |            when undefined lapCount is tied to zero.                |
// | Revision : 1.0  initial release                                    |
// +--------------------------------------------------------------------+
module stopwatch_ctrl #(
  parameter int DB_TICKS = 20,
  parameter int DB_W     = 5
) (
  input  wire              clkIn,
  input  wire              resetN,
  stopwatch_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    LAP   = 2'd2,
    PAUSE = 2'd3
  } state_t;

  // Counter value on which the next differing tick completes the debounce.
  localparam logic [DB_W-1:0] c_DB_LAST = DB_W'(DB_TICKS - 1);

  logic [1:0] w_btn_raw;
  logic [1:0] w_press;
  logic       w_ssP;
  logic       w_lrP;

  assign w_btn_raw = {bus.btnLR, bus.btnSS};
  assign w_ssP     = w_press[0];
  assign w_lrP     = w_press[1];

  // Per-button synchroniser, debouncer and rising-edge detector.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_btn
      logic            r_sync1;
      logic            r_sync2;
      logic            r_deb;
      logic            r_deb_d;
      logic [DB_W-1:0] r_cnt;

      // Sync the raw level, count ticks of disagreement, accept after DB_TICKS.
      always_ff @(posedge clkIn or negedge resetN) begin
        if (!resetN) begin
          r_sync1 <= 1'b0;
          r_sync2 <= 1'b0;
          r_deb   <= 1'b0;
          r_deb_d <= 1'b0;
          r_cnt   <= '0;
        end else begin
          r_sync1 <= w_btn_raw[gi];
          r_sync2 <= r_sync1;
          r_deb_d <= r_deb;
          if (bus.tickIn) begin
            if (r_sync2 != r_deb) begin
              if (r_cnt == c_DB_LAST) begin
                r_deb <= r_sync2;
                r_cnt <= '0;
              end else begin
                r_cnt <= r_cnt + DB_W'(1);
              end
            end else begin
              r_cnt <= '0;
            end
          end
        end
      end

      // Releases are ignored: only the debounced 0->1 edge is an event.
      assign w_press[gi] = r_deb & ~r_deb_d;
    end
  endgenerate

  state_t      r_state;
  state_t      w_next;
  logic        w_clr;
  logic        w_cap;
  logic        r_timerEn;
  logic        r_timerClr;
  logic [29:0] r_lap;
  logic [29:0] r_disp;

  // Next-state decode; start/stop has priority over lap/reset.
  always_comb begin
    w_next = r_state;
    w_clr  = 1'b0;
    w_cap  = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_ssP)      w_next = RUN;
        else if (w_lrP) w_clr  = 1'b1;
      end
      RUN: begin
        if (w_ssP) begin
          w_next = PAUSE;
        end else if (w_lrP) begin
          w_next = LAP;
          w_cap  = 1'b1;
        end
      end
      LAP: begin
        if (w_ssP)      w_next = PAUSE;
        else if (w_lrP) w_next = RUN;
      end
      PAUSE: begin
        if (w_ssP) begin
          w_next = RUN;
        end else if (w_lrP) begin
          w_next = IDLE;
          w_clr  = 1'b1;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  // State, registered timer controls, lap capture and display mux.
  always_ff @(posedge clkIn or negedge resetN) begin
    if (!resetN) begin
      r_state    <= IDLE;
      r_timerEn  <= 1'b0;
      r_timerClr <= 1'b0;
      r_lap      <= '0;
      r_disp     <= '0;
    end else begin
      r_state    <= w_next;
      r_timerEn  <= (w_next == RUN) || (w_next == LAP);
      r_timerClr <= w_clr;
      if (w_cap) r_lap <= bus.timeIn;
      r_disp     <= (r_state == LAP) ? r_lap : bus.timeIn;
    end
  end

`ifdef LAP_COUNT_EN
  localparam logic [3:0] c_LAP_MAX = 4'd15;
  logic [3:0] r_lap_cnt;

  // Saturating count of RUN->LAP entries, cleared together with the timer.
  always_ff @(posedge clkIn or negedge resetN) begin
    if (!resetN) begin
      r_lap_cnt <= 4'd0;
    end else if (w_clr) begin
      r_lap_cnt <= 4'd0;
    end else if (w_cap && (r_lap_cnt != c_LAP_MAX)) begin
      r_lap_cnt <= r_lap_cnt + 4'd1;
    end
  end

  assign bus.lapCount = r_lap_cnt;
`else
  assign bus.lapCount = 4'd0;
`endif

  assign bus.state    = r_state;
  assign bus.timerEn  = r_timerEn;
  assign bus.timerClr = r_timerClr;
  assign bus.dispOut  = r_disp;

endmodule
`default_nettype wire

// File: tb/tb_stopwatch_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module   : tb_stopwatch_ctrl                                       |
// | Purpose  : Directed self-checking bench for stopwatch_ctrl with a  |
// |            short debounce (DB_TICKS=2, tick every 10 clocks).      |
// | Revision : 1.0  initial release                                    |
// +--------------------------------------------------------------------+
module tb_stopwatch_ctrl;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;
  int   clr_cnt;
  logic [3:0] exp_lap;

  stopwatch_ctrl_if sw ();

  stopwatch_ctrl #(
    .DB_TICKS (2),
    .DB_W     (5)
  ) dut (
    .clkIn  (clk),
    .resetN (rst_n),
    .bus    (sw)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // 1 ms tick stand-in: one-cycle pulse every 10 clocks.
  initial begin
    sw.tickIn = 1'b0;
    forever begin
      repeat (9) @(negedge clk);
      sw.tickIn = 1'b1;
      @(negedge clk);
      sw.tickIn = 1'b0;
    end
  end

  // Count clock cycles during which timerClr is high.
  initial begin
    clr_cnt = 0;
    forever begin
      @(negedge clk);
      if (sw.timerClr) clr_cnt++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Hold buttons long enough to debounce, then release and let it settle.
  task automatic press(input logic ss, input logic lr);
    sw.btnSS = ss;
    sw.btnLR = lr;
    repeat (40) @(negedge clk);
    sw.btnSS = 1'b0;
    sw.btnLR = 1'b0;
    repeat (40) @(negedge clk);
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    rst_n     = 1'b0;
    sw.btnSS  = 1'b0;
    sw.btnLR  = 1'b0;
    sw.timeIn = 30'h0;

    // Reset state
    repeat (5) @(negedge clk);
    chk("rst_state", 32'(sw.state), 32'd0);
    chk("rst_en", 32'(sw.timerEn), 32'd0);
    chk("rst_clr", 32'(sw.timerClr), 32'd0);
    chk("rst_disp", 32'(sw.dispOut), 32'd0);
    chk("rst_lapcnt", 32'(sw.lapCount), 32'd0);
    rst_n = 1'b1;
    repeat (30) @(negedge clk);
    chk("post_rst_state", 32'(sw.state), 32'd0);
    chk("post_rst_en", 32'(sw.timerEn), 32'd0);
    chk("post_rst_clr_cnt", 32'(clr_cnt), 32'd0);

    // Debounce: short glitch rejected
    sw.btnSS = 1'b1;
    repeat (8) @(negedge clk);
    sw.btnSS = 1'b0;
    repeat (40) @(negedge clk);
    chk("glitch_state", 32'(sw.state), 32'd0);

    // Debounce: held 3 ticks accepted exactly once
    sw.btnSS = 1'b1;
    repeat (30) @(negedge clk);
    chk("hold_state", 32'(sw.state), 32'd1);
    chk("hold_en", 32'(sw.timerEn), 32'd1);
    repeat (40) @(negedge clk);
    chk("hold_long_state", 32'(sw.state), 32'd1);
    sw.btnSS = 1'b0;
    repeat (40) @(negedge clk);

    // Lap freeze
    sw.timeIn = 30'h00012345;
    press(1'b0, 1'b1);
    chk("lap_state", 32'(sw.state), 32'd2);
    chk("lap_disp0", 32'(sw.dispOut), 32'h00012345);
    sw.timeIn = 30'h00012400;
    repeat (5) @(negedge clk);
    chk("lap_disp_frozen", 32'(sw.dispOut), 32'h00012345);
    chk("lap_en", 32'(sw.timerEn), 32'd1);
`ifdef LAP_COUNT_EN
    exp_lap = 4'd1;
`else
    exp_lap = 4'd0;
`endif
    chk("lap_cnt1", 32'(sw.lapCount), 32'(exp_lap));
    press(1'b0, 1'b1);
    chk("unlap_state", 32'(sw.state), 32'd1);
    chk("unlap_disp", 32'(sw.dispOut), 32'h00012400);
    sw.timeIn = 30'h00012401;
    #1;
    chk("track_before_edge", 32'(sw.dispOut), 32'h00012400);
    @(negedge clk);
    chk("track_after_edge", 32'(sw.dispOut), 32'h00012401);

    // Simultaneous presses from RUN: start/stop wins
    sw.timeIn = 30'h0000ABCD;
    press(1'b1, 1'b1);
    chk("simul_state", 32'(sw.state), 32'd3);
    chk("simul_en", 32'(sw.timerEn), 32'd0);
    chk("simul_lapcnt", 32'(sw.lapCount), 32'(exp_lap));
    chk("simul_disp", 32'(sw.dispOut), 32'h0000ABCD);
    chk("simul_clr_cnt", 32'(clr_cnt), 32'd0);

    // Pause / clear
    press(1'b1, 1'b0);
    chk("resume_state", 32'(sw.state), 32'd1);
    press(1'b1, 1'b0);
    chk("pause_state", 32'(sw.state), 32'd3);
    chk("pause_en", 32'(sw.timerEn), 32'd0);
    press(1'b0, 1'b1);
    chk("clear_state", 32'(sw.state), 32'd0);
    chk("clear_pulse_cnt", 32'(clr_cnt), 32'd1);
    chk("clear_pulse_low", 32'(sw.timerClr), 32'd0);
    chk("clear_lapcnt", 32'(sw.lapCount), 32'd0);
    press(1'b0, 1'b1);
    chk("idle_clr_state", 32'(sw.state), 32'd0);
    chk("idle_clr_cnt", 32'(clr_cnt), 32'd2);

    // Lap counter saturation over 17 laps
    press(1'b1, 1'b0);
    for (int i = 0; i < 17; i++) begin
      press(1'b0, 1'b1);
      press(1'b0, 1'b1);
    end
    chk("sat_state", 32'(sw.state), 32'd1);
`ifdef LAP_COUNT_EN
    exp_lap = 4'd15;
`else
    exp_lap = 4'd0;
`endif
    chk("sat_lapcnt", 32'(sw.lapCount), 32'(exp_lap));
    press(1'b1, 1'b0);
    chk("sat_pause_lapcnt", 32'(sw.lapCount), 32'(exp_lap));
    press(1'b0, 1'b1);
    chk("sat_clear_state", 32'(sw.state), 32'd0);
    chk("sat_clear_lapcnt", 32'(sw.lapCount), 32'd0);
    chk("sat_clear_cnt", 32'(clr_cnt), 32'd3);

    // Asynchronous reset mid-operation and mid-debounce
    press(1'b1, 1'b0);
    sw.timeIn = 30'h00000003;
    press(1'b0, 1'b1);
    chk("pre_rst_state", 32'(sw.state), 32'd2);
    sw.timeIn = 30'h00000007;
    sw.btnSS = 1'b1;
    repeat (15) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_state", 32'(sw.state), 32'd0);
    chk("async_rst_en", 32'(sw.timerEn), 32'd0);
    chk("async_rst_disp", 32'(sw.dispOut), 32'd0);
    chk("async_rst_lapcnt", 32'(sw.lapCount), 32'd0);
    repeat (25) @(negedge clk);
    sw.btnSS = 1'b0;
    rst_n = 1'b1;
    repeat (60) @(negedge clk);
    chk("after_rst_state", 32'(sw.state), 32'd0);
    chk("after_rst_disp", 32'(sw.dispOut), 32'h00000007);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/stopwatch_ctrl.md
Name: stopwatch_ctrl

Overview:
- Control FSM that sequences the millisecond timer as a two-button stopwatch: start/stop, lap, and clear.
- Sits between the raw push-buttons and the timer datapath (clock divider → timer → hexDriver chain).
- Gates the timer's count enable and issues its clear pulses.
- Selects the live time or a frozen lap value for the hex display path.

Parameters:
DB_TICKS, 20, consecutive 1 ms ticks a synchronised button level must hold before it is accepted (20 ms debounce)
DB_W, 5, width of each debounce counter; must satisfy 2**DB_W > DB_TICKS

Ports:
clkIn  input  1  system clock, 50 MHz
resetN  input  1  asynchronous, active-low reset
tickIn  input  1  1 kHz enable; one clkIn-cycle pulse per ms, synchronous to clkIn
btnSS  input  1  raw start/stop button, active-high, asynchronous
btnLR  input  1  raw lap/reset button, active-high, asynchronous
timeIn  input  30  current timer value (six 5-bit digit fields), treated as opaque
timerEn  output  1  count enable to timer
timerClr  output  1  one-cycle clear pulse to timer
dispOut  output  30  value forwarded to the six hexDriver instances
state  output  2  FSM state: 0 IDLE, 1 RUN, 2 LAP, 3 PAUSE
lapCount  output  4  laps taken since last clear (see Optional Feature)

Behaviour:
- Interface: one clock, clkIn. resetN is asynchronous and active-low; assertion takes effect immediately, with no clock edge required.
- Reset values:
  - state = IDLE, timerEn = 0, timerClr = 0.
  - dispOut = 0, lapCount = 0.
  - Lap register = 0, debounce counters = 0, debounced levels = 0.
- Input conditioning, per button:
  - 2-FF synchroniser on clkIn.
  - Debounce: on each tickIn, if the synchronised level differs from the debounced level, increment the counter; otherwise clear it.
  - When the counter reaches DB_TICKS, the debounced level takes the new value and the counter clears.
  - Press event = one-cycle pulse on the debounced 0→1 edge. Releases generate nothing.
- Transitions, evaluated on each clkIn edge using the press pulses ssP and lrP:
  - IDLE: ssP → RUN. lrP → stay in IDLE, pulse timerClr.
  - RUN: ssP → PAUSE. lrP → LAP, capturing timeIn into the lap register on the same edge.
  - LAP: ssP → PAUSE. lrP → RUN.
  - PAUSE: ssP → RUN. lrP → IDLE, pulse timerClr.
- Simultaneous ssP and lrP in one cycle: ssP wins and lrP is discarded.
- timerEn is registered and equals 1 exactly when the next state is RUN or LAP, so it changes on the same edge as state.
- timerClr is a registered pulse, high for exactly one clkIn cycle, asserted on the edge that takes the transition.
- dispOut is registered, with 1 clkIn cycle latency from timeIn:
  - In LAP: dispOut = lap register (frozen while the timer keeps counting).
  - In every other state: dispOut = timeIn.
- On entering LAP, dispOut shows the captured value from the next cycle onward.
- The block never inspects timeIn contents; wrap-around of the timer is the timer's own concern.
- tickIn pulses arriving during reset are ignored.
- Reset mid-operation (e.g. in LAP or mid-debounce) returns everything to reset values. Any partially debounced press is lost.

Optional Feature:
Macro LAP_COUNT_EN.
- Defined:
  - lapCount increments on every RUN→LAP transition.
  - Saturates at 15.
  - Clears to 0 on every timerClr pulse and on reset.
- Undefined: no lap counter logic; the lapCount port remains and is driven constant 4'd0.

Test Plan (bench overrides DB_TICKS=2; tickIn every 10 clkIn cycles):
- Reset: hold resetN=0 → state=0, timerEn=0, timerClr=0, dispOut=0, lapCount=0. Release → outputs unchanged with no buttons pressed.
- Debounce: btnSS glitch high for 1 tick then low → state stays 0. btnSS held high for 3 ticks → exactly one ssP, state=1, timerEn=1; holding longer gives no further transition.
- Lap freeze: in RUN with timeIn=30'h00012345, press btnLR → state=2, dispOut=30'h00012345 constant while timeIn advances to 30'h00012400, timerEn=1. Press btnLR again → state=1, dispOut tracks timeIn one cycle late.
- Pause/clear: RUN → btnSS → state=3, timerEn=0. btnLR → state=0, timerClr high exactly 1 cycle. btnLR again in IDLE → another single timerClr pulse, state=0.
- Simultaneous: force ssP and lrP in the same cycle from RUN → state=3, no lap capture, lapCount unchanged.
- LAP_COUNT_EN defined: 17 RUN→LAP→RUN cycles → lapCount=15 (saturated); PAUSE then clear → lapCount=0. Undefined: lapCount=0 throughout.
